// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks E/M/W destination tags, drives stall/flush
// controls and execute-stage forwarding selects, and counts stall/redirect cycles.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              Use1_D,
  input  logic              Use2_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic              RegWrite_D,
  input  logic              IsLoad_D,
  input  logic              PCSrc_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              e_valid_reg, m_valid_reg, w_valid_reg;
  logic [REG_AW-1:0] e_rd_reg, m_rd_reg, w_rd_reg;
  logic              e_rw_reg, m_rw_reg, w_rw_reg;
  logic              e_ld_reg;
  logic [REG_AW-1:0] e_rs1_reg, e_rs2_reg;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

  logic       e_prod, m_prod, w_prod;
  logic       hit_e, hit_m, hazard;
  logic       stall, flush_e;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    e_prod = e_valid_reg & e_rw_reg & (e_rd_reg != '0);
    m_prod = m_valid_reg & m_rw_reg & (m_rd_reg != '0);
    w_prod = w_valid_reg & w_rw_reg & (w_rd_reg != '0);

    hit_e = e_prod & ((Use1_D & (Rs1_D == e_rd_reg)) | (Use2_D & (Rs2_D == e_rd_reg)));
    hit_m = m_prod & ((Use1_D & (Rs1_D == m_rd_reg)) | (Use2_D & (Rs2_D == m_rd_reg)));

    // With forwarding only a load in E is too late; without it, E and M both block.
    hazard = (FWD_EN != 0) ? (hit_e & e_ld_reg) : (hit_e | hit_m);

    // A redirect kills the stalled instruction anyway, so it wins over the stall.
    stall   = hazard & ~PCSrc_E;
    flush_e = PCSrc_E | hazard;

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (m_prod && (m_rd_reg == e_rs1_reg))      fwd_a = 2'b10;
      else if (w_prod && (w_rd_reg == e_rs1_reg)) fwd_a = 2'b01;
      if (m_prod && (m_rd_reg == e_rs2_reg))      fwd_b = 2'b10;
      else if (w_prod && (w_rd_reg == e_rs2_reg)) fwd_b = 2'b01;
    end
  end

  // Reset masks every control output, even an in-flight redirect.
  assign Stall_F    = rst & stall;
  assign Stall_D    = rst & stall;
  assign Flush_D    = rst & PCSrc_E;
  assign Flush_E    = rst & flush_e;
  assign ForwardA_E = rst ? fwd_a : 2'b00;
  assign ForwardB_E = rst ? fwd_b : 2'b00;
  assign StallCnt   = stall_cnt_reg;
  assign FlushCnt   = flush_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid_reg <= 1'b0;
      e_rd_reg    <= '0;
      e_rw_reg    <= 1'b0;
      e_ld_reg    <= 1'b0;
      e_rs1_reg   <= '0;
      e_rs2_reg   <= '0;
      m_valid_reg <= 1'b0;
      m_rd_reg    <= '0;
      m_rw_reg    <= 1'b0;
      w_valid_reg <= 1'b0;
      w_rd_reg    <= '0;
      w_rw_reg    <= 1'b0;
    end else begin
      // Bubbles carry zero sources so they can never select a forward path.
      if (flush_e) begin
        e_valid_reg <= 1'b0;
        e_rd_reg    <= '0;
        e_rw_reg    <= 1'b0;
        e_ld_reg    <= 1'b0;
        e_rs1_reg   <= '0;
        e_rs2_reg   <= '0;
      end else begin
        e_valid_reg <= 1'b1;
        e_rd_reg    <= Rd_D;
        e_rw_reg    <= RegWrite_D;
        e_ld_reg    <= IsLoad_D;
        e_rs1_reg   <= Rs1_D;
        e_rs2_reg   <= Rs2_D;
      end
      m_valid_reg <= e_valid_reg;
      m_rd_reg    <= e_rd_reg;
      m_rw_reg    <= e_rw_reg;
      w_valid_reg <= m_valid_reg;
      w_rd_reg    <= m_rd_reg;
      w_rw_reg    <= m_rw_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (PCSrc_E && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a forwarding instance driven from a vector table,
// plus an interlock instance with narrow counters for stall timing and saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       use1_d = 1'b0, use2_d = 1'b0, rw_d = 1'b0, ld_d = 1'b0, pc_e = 1'b0;

  logic        f_stall_f, f_stall_d, f_flush_d, f_flush_e;
  logic [1:0]  f_fa, f_fb;
  logic [31:0] f_sc, f_fc;
  logic        i_stall_f, i_stall_d, i_flush_d, i_flush_e;
  logic [1:0]  i_fa, i_fb;
  logic [1:0]  i_sc, i_fc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(32)) u_fwd (
    .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Use1_D(use1_d), .Use2_D(use2_d),
    .Rd_D(rd_d), .RegWrite_D(rw_d), .IsLoad_D(ld_d), .PCSrc_E(pc_e),
    .Stall_F(f_stall_f), .Stall_D(f_stall_d), .Flush_D(f_flush_d), .Flush_E(f_flush_e),
    .ForwardA_E(f_fa), .ForwardB_E(f_fb), .StallCnt(f_sc), .FlushCnt(f_fc));

  hazard_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) u_ilk (
    .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Use1_D(use1_d), .Use2_D(use2_d),
    .Rd_D(rd_d), .RegWrite_D(rw_d), .IsLoad_D(ld_d), .PCSrc_E(pc_e),
    .Stall_F(i_stall_f), .Stall_D(i_stall_d), .Flush_D(i_flush_d), .Flush_E(i_flush_e),
    .ForwardA_E(i_fa), .ForwardB_E(i_fb), .StallCnt(i_sc), .FlushCnt(i_fc));

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, pc;
    logic       st, fd, fe;
    logic [1:0] fa, fb;
    int         sc, fc;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int rd, int rw, int ld, int pc,
                              int st, int fd, int fe, int fa, int fb, int sc, int fc);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.rw = 1'(rw); v.ld = 1'(ld); v.pc = 1'(pc);
    v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe); v.fa = 2'(fa); v.fb = 2'(fb);
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input int u1, input int u2,
                       input int rd, input int rw, input int ld, input int pc);
    rs1_d = 5'(rs1); rs2_d = 5'(rs2); use1_d = 1'(u1); use2_d = 1'(u2);
    rd_d = 5'(rd); rw_d = 1'(rw); ld_d = 1'(ld); pc_e = 1'(pc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " fwd stall_f"}, int'(f_stall_f), 0);
    chk({tag, " fwd stall_d"}, int'(f_stall_d), 0);
    chk({tag, " fwd flush_d"}, int'(f_flush_d), 0);
    chk({tag, " fwd flush_e"}, int'(f_flush_e), 0);
    chk({tag, " fwd fa"}, int'(f_fa), 0);
    chk({tag, " fwd fb"}, int'(f_fb), 0);
    chk({tag, " fwd stallcnt"}, int'(f_sc), 0);
    chk({tag, " fwd flushcnt"}, int'(f_fc), 0);
    chk({tag, " ilk stall_d"}, int'(i_stall_d), 0);
    chk({tag, " ilk flush_d"}, int'(i_flush_d), 0);
    chk({tag, " ilk flush_e"}, int'(i_flush_e), 0);
    chk({tag, " ilk stallcnt"}, int'(i_sc), 0);
    chk({tag, " ilk flushcnt"}, int'(i_fc), 0);
  endtask

  initial begin
    // Forwarding instance: one D instruction per row, outputs checked mid-cycle.
    tbl[0]  = mk( 1, 2, 1, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0); // producer x5
    tbl[1]  = mk( 5, 0, 1, 0,  8, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0); // consumer rs1=5
    tbl[2]  = mk( 3, 5, 1, 1,  9, 1, 0, 0,  0, 0, 0, 2, 0, 0, 0); // fwdA from M
    tbl[3]  = mk( 2, 0, 1, 0,  6, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0); // fwdB from W; load x6
    tbl[4]  = mk( 1, 6, 1, 1, 10, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0); // load-use stall
    tbl[5]  = mk( 1, 6, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0); // held, bubble in E
    tbl[6]  = mk( 0, 0, 1, 0,  0, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0); // load result via W; x0 producer
    tbl[7]  = mk( 0, 0, 1, 1, 11, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0); // x0 consumer: no forward
    tbl[8]  = mk(11, 0, 0, 0,  0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0); // rs1 matches load but unused
    tbl[9]  = mk( 0, 0, 1, 1, 12, 1, 0, 0,  0, 0, 0, 2, 0, 1, 0); // load to x0 in E: no stall
    tbl[10] = mk( 0, 0, 0, 0,  6, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0); // load x6
    tbl[11] = mk( 6, 0, 1, 0, 13, 1, 0, 1,  0, 1, 1, 0, 0, 1, 0); // redirect beats load-use
    tbl[12] = mk( 0, 0, 0, 0,  6, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1); // ALU x6 (a)
    tbl[13] = mk( 0, 0, 0, 0,  6, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1); // ALU x6 (b)
    tbl[14] = mk( 6, 6, 1, 1, 14, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1); // consumer of x6 both ops
    tbl[15] = mk( 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2, 2, 1, 1); // M beats W
    tbl[16] = mk( 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);

    // Reset held with a redirect and matching sources: everything must read 0.
    drive(5, 5, 1, 1, 5, 1, 1, 1);
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    $display("reset: held low with PCSrc_E=1, outputs checked");

    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("release fwd fa", int'(f_fa), 0);
    chk("release fwd fb", int'(f_fb), 0);
    chk("release fwd stall_d", int'(f_stall_d), 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc);
      #1;
      chk($sformatf("row%0d stall_f", i), int'(f_stall_f), int'(tbl[i].st));
      chk($sformatf("row%0d stall_d", i), int'(f_stall_d), int'(tbl[i].st));
      chk($sformatf("row%0d flush_d", i), int'(f_flush_d), int'(tbl[i].fd));
      chk($sformatf("row%0d flush_e", i), int'(f_flush_e), int'(tbl[i].fe));
      chk($sformatf("row%0d fwd_a", i), int'(f_fa), int'(tbl[i].fa));
      chk($sformatf("row%0d fwd_b", i), int'(f_fb), int'(tbl[i].fb));
      chk($sformatf("row%0d stallcnt", i), int'(f_sc), tbl[i].sc);
      chk($sformatf("row%0d flushcnt", i), int'(f_fc), tbl[i].fc);
      $display("row%0d: rs1=%0d rs2=%0d rd=%0d ld=%0d pc=%0d -> st=%0d fe=%0d fa=%0d fb=%0d sc=%0d fc=%0d",
               i, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].ld, tbl[i].pc,
               f_stall_d, f_flush_e, f_fa, f_fb, f_sc, f_fc);
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(0, 0, 0, 0, 6, 1, 1, 0);
    @(negedge clk);
    drive(0, 6, 0, 1, 10, 1, 0, 0);
    #1;
    chk("midstall stall_d before reset", int'(f_stall_d), 1);
    rst = 1'b0;
    #1;
    chk("midstall stall_d in reset", int'(f_stall_d), 0);
    chk("midstall flush_e in reset", int'(f_flush_e), 0);
    chk("midstall stallcnt in reset", int'(f_sc), 0);
    chk("midstall flushcnt in reset", int'(f_fc), 0);
    chk("midstall ilk stallcnt in reset", int'(i_sc), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midstall stall_d after release", int'(f_stall_d), 0);
    $display("midstall: async reset cleared stall and counters");
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Interlock instance: producer x7 in E, consumer rs1=7 held in D.
    @(negedge clk);
    drive(0, 0, 0, 0, 7, 1, 0, 0);
    #1;
    chk("ilk A stall_d", int'(i_stall_d), 0);
    @(negedge clk);
    drive(7, 0, 1, 0, 15, 1, 0, 0);
    #1;
    chk("ilk B stall_d", int'(i_stall_d), 1);
    chk("ilk B stall_f", int'(i_stall_f), 1);
    chk("ilk B fwd_a", int'(i_fa), 0);
    chk("ilk B stallcnt", int'(i_sc), 0);
    $display("ilk B: producer in E -> stall_d=%0d", i_stall_d);
    @(negedge clk);
    #1;
    chk("ilk C stall_d", int'(i_stall_d), 1);
    chk("ilk C fwd_a", int'(i_fa), 0);
    chk("ilk C stallcnt", int'(i_sc), 1);
    $display("ilk C: producer in M -> stall_d=%0d", i_stall_d);
    @(negedge clk);
    #1;
    chk("ilk D stall_d", int'(i_stall_d), 0);
    chk("ilk D stallcnt", int'(i_sc), 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ilk E fwd_a", int'(i_fa), 0);
    chk("ilk E stallcnt", int'(i_sc), 2);
    $display("ilk E: stall released, stallcnt=%0d", i_sc);

    // Redirect every cycle: the 2-bit flush counter must stick at 3.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk($sformatf("sat%0d flush_d", k), int'(i_flush_d), 1);
      chk($sformatf("sat%0d flushcnt", k), int'(i_fc), (k > 3) ? 3 : k);
      chk($sformatf("sat%0d stallcnt", k), int'(i_sc), 2);
      $display("sat%0d: flushcnt=%0d", k, i_fc);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat end flushcnt", int'(i_fc), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
